// File: rtl/snake_head_ctrl.sv
// Snake head controller: steers the head from key pulses, moves it on each tick,
// detects collisions, broadcasts length/eat events and requests new apples.
module snake_head_ctrl #(
  parameter int unsigned GRID_W   = 16,
  parameter int unsigned GRID_H   = 16,
  parameter int unsigned START_X  = 4,
  parameter int unsigned START_Y  = 8,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned MAX_LEN  = 255,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_left,
  input  logic          key_right,
  input  logic          tick,
  input  logic          occupied,
  input  logic          apple_ack,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  output logic [1:0]    direction,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic [7:0]    hold_time,
  output logic          eat_apple,
  output logic          apple_req,
  output logic          apple_valid,
  output logic          game_over
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
  typedef enum logic [1:0] {D_RIGHT = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_UP = 2'b11} dir_t;

  state_t        r_state, w_state_n;
  dir_t          r_dir, w_dir_n, r_pend, w_pend_n, w_key_dir;
  logic [XW-1:0] r_head_x, w_head_x_n, r_apple_x, w_apple_x_n, w_next_x;
  logic [YW-1:0] r_head_y, w_head_y_n, r_apple_y, w_apple_y_n, w_next_y;
  logic [7:0]    r_hold, w_hold_n;
  logic          r_eat, w_eat_n, r_req, w_req_n, r_valid, w_valid_n;
  logic          w_key_any, w_off_grid;

  assign w_key_any = key_up | key_down | key_left | key_right;

  always_comb begin
    if (key_up)        w_key_dir = D_UP;
    else if (key_down) w_key_dir = D_DOWN;
    else if (key_left) w_key_dir = D_LEFT;
    else               w_key_dir = D_RIGHT;
  end

  // Candidate position wraps silently at the edges; w_off_grid flags those moves.
  always_comb begin
    w_next_x   = r_head_x;
    w_next_y   = r_head_y;
    w_off_grid = 1'b0;
    case (r_pend)
      D_RIGHT: begin
        w_next_x   = r_head_x + XW'(1);
        w_off_grid = (r_head_x == XW'(GRID_W - 1));
      end
      D_LEFT: begin
        w_next_x   = r_head_x - XW'(1);
        w_off_grid = (r_head_x == '0);
      end
      D_UP: begin
        w_next_y   = r_head_y + YW'(1);
        w_off_grid = (r_head_y == YW'(GRID_H - 1));
      end
      default: begin
        w_next_y   = r_head_y - YW'(1);
        w_off_grid = (r_head_y == '0);
      end
    endcase
  end

  always_comb begin
    w_state_n   = r_state;
    w_dir_n     = r_dir;
    w_pend_n    = r_pend;
    w_head_x_n  = r_head_x;
    w_head_y_n  = r_head_y;
    w_hold_n    = r_hold;
    w_eat_n     = 1'b0;
    w_req_n     = r_req;
    w_valid_n   = r_valid;
    w_apple_x_n = r_apple_x;
    w_apple_y_n = r_apple_y;
    case (r_state)
      S_IDLE: begin
        if (key_up | key_down | key_right) begin
          w_state_n = S_RUN;
          w_pend_n  = key_up ? D_UP : (key_down ? D_DOWN : D_RIGHT);
          w_req_n   = 1'b1;
        end
      end
      S_RUN: begin
        if (r_req && apple_ack) begin
          w_apple_x_n = apple_x;
          w_apple_y_n = apple_y;
          w_valid_n   = 1'b1;
          w_req_n     = 1'b0;
        end
        // Tick evaluates with the pre-key pend_dir and pre-ack apple state.
        if (tick) begin
          if (w_off_grid || occupied) begin
            w_state_n = S_OVER;
            w_req_n   = 1'b0;
          end else begin
            w_head_x_n = w_next_x;
            w_head_y_n = w_next_y;
            w_dir_n    = r_pend;
            if (r_valid && (w_next_x == r_apple_x) && (w_next_y == r_apple_y)) begin
              w_eat_n   = 1'b1;
              w_hold_n  = (r_hold >= 8'(MAX_LEN)) ? r_hold : r_hold + 8'd1;
              w_valid_n = 1'b0;
              w_req_n   = 1'b1;
            end
          end
        end
        if (w_key_any && (w_key_dir != dir_t'(r_dir ^ 2'b10)))
          w_pend_n = w_key_dir;
      end
      default: w_req_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_dir     <= D_RIGHT;
      r_pend    <= D_RIGHT;
      r_head_x  <= XW'(START_X);
      r_head_y  <= YW'(START_Y);
      r_hold    <= 8'(INIT_LEN);
      r_eat     <= 1'b0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_apple_x <= '0;
      r_apple_y <= '0;
    end else begin
      r_state   <= w_state_n;
      r_dir     <= w_dir_n;
      r_pend    <= w_pend_n;
      r_head_x  <= w_head_x_n;
      r_head_y  <= w_head_y_n;
      r_hold    <= w_hold_n;
      r_eat     <= w_eat_n;
      r_req     <= w_req_n;
      r_valid   <= w_valid_n;
      r_apple_x <= w_apple_x_n;
      r_apple_y <= w_apple_y_n;
    end
  end

  assign direction   = r_dir;
  assign head_x      = r_head_x;
  assign head_y      = r_head_y;
  assign next_x      = w_next_x;
  assign next_y      = w_next_y;
  assign hold_time   = r_hold;
  assign eat_apple   = r_eat;
  assign apple_req   = r_req;
  assign apple_valid = r_valid;
  assign game_over   = (r_state == S_OVER);

endmodule

// File: doc/snake_head_ctrl.md
Name: snake_head_ctrl

Overview:
- Game-level driver for the per-cell light array: owns snake direction, head position, length (hold time) and the apple-eaten event that every cell consumes.
- Turns debounced key pulses and a move tick into the broadcast `direction`, `hold_time` and `eat_apple` signals.
- Requests new apple positions from the apple generator through a req/ack handshake.
- Detects wall and body collisions and signals game over.

Parameters:
- GRID_W, 16, grid columns; x range 0..GRID_W-1.
- GRID_H, 16, grid rows; y range 0..GRID_H-1, y increases upward.
- START_X, 4, head x after reset.
- START_Y, 8, head y after reset.
- INIT_LEN, 3, hold_time after reset (head plus 2 trailing body segments).
- MAX_LEN, 255, saturation value of hold_time.

Ports:
- clk  in  1  system clock (modified game clock).
- reset  in  1  asynchronous, active-low reset.
- key_up, key_down, key_left, key_right  in  1 each  one-cycle debounced press pulses.
- tick  in  1  one-cycle move strobe.
- occupied  in  1  combinational lookup from the cell array: cell at (next_x,next_y) is body or border.
- apple_ack  in  1  apple generator has put a valid position on apple_x/apple_y.
- apple_x  in  $clog2(GRID_W)  new apple column.
- apple_y  in  $clog2(GRID_H)  new apple row.
- direction  out  2  committed direction: right=00, down=01, left=10, up=11.
- head_x, head_y  out  coord widths  current head position.
- next_x, next_y  out  coord widths  combinational candidate head position, computed from pend_dir.
- hold_time  out  8  current snake length, broadcast to cells.
- eat_apple  out  1  one-cycle pulse, aligned with the head update.
- apple_req  out  1  request for a new apple position.
- apple_valid  out  1  a stored apple position is live.
- game_over  out  1  high in OVER state.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, head=(START_X,START_Y), direction=pend_dir=right, hold_time=INIT_LEN.
  - eat_apple=0, apple_req=0, apple_valid=0, game_over=0; stored apple cleared to 0.
  - Reset mid-game aborts everything, including an outstanding apple_req.
- States: IDLE, RUN, OVER.
- IDLE:
  - Ticks are ignored.
  - Any key except key_left → RUN next cycle. pend_dir is set from that key; apple_req is raised.
  - key_left in IDLE is ignored (it would reverse the initial right direction).
- Key handling in RUN:
  - If multiple keys arrive in one cycle, priority is up > down > left > right.
  - A key equal to the reverse of the committed `direction` (not pend_dir) is ignored.
  - Otherwise pend_dir <= key. Later keys before a tick overwrite pend_dir.
- next_x/next_y: head ±1 along pend_dir; the value is meaningless when the move would leave the grid.
- Tick in RUN (all updates registered, visible the cycle after the tick):
  - If the move leaves the grid, or occupied=1 → OVER. Head, direction and hold_time hold; eat_apple stays 0.
  - Else: head<=next, direction<=pend_dir.
  - If additionally apple_valid=1 and next==stored apple:
    - eat_apple<=1 for exactly one cycle.
    - hold_time<=min(hold_time+1, MAX_LEN).
    - apple_valid<=0 and apple_req<=1.
- A key in the same cycle as a tick updates pend_dir after the tick evaluates, so it applies to the following tick.
- Apple handshake:
  - apple_req stays high until a cycle with apple_ack=1.
  - On that edge: apple_x/y are stored, apple_valid<=1, apple_req<=0.
  - apple_ack while apple_req=0 is ignored.
  - If ack and tick coincide, the tick's eat check uses the pre-ack state (apple_valid=0, so no eat).
- OVER:
  - Terminal until reset; keys, ticks and ack are ignored.
  - apple_req drops to 0.
  - game_over=1, registered, asserted the cycle after the fatal tick.
- hold_time never exceeds MAX_LEN and never decrements.

Test Plan:
1. Reset, then key_right, ack apple at (10,8), 6 ticks → head moves (4,8)→(10,8); eat_apple pulses once after the 6th tick; hold_time 3→4; apple_req reasserts.
2. In RUN heading right, pulse key_left → ignored; pulse key_up then key_left before the next tick → pend_dir=left is rejected only if direction=left-reverse. Expect direction=up after the tick, head_y+1.
3. Head at (15,y) heading right, tick → game_over=1 the next cycle; head stays (15,y); a further key/tick changes nothing.
4. Drive occupied=1 at a tick → OVER; with occupied=0 the same move succeeds.
5. Hold apple_ack low for 20 cycles → apple_req stays high and apple_valid=0 throughout; ticks pass the apple coordinates without eating. Assert ack → apple_valid=1 the next cycle.
6. Preset hold_time=MAX_LEN via repeated eats (MAX_LEN=5 override) → the 3rd eat keeps hold_time=5 and eat_apple still pulses. Drop reset mid-run → all outputs return to reset values asynchronously.
